// File: rtl/jk_toggle_monitor.sv
// Edge monitor for a JK/T flip-flop output: synchronises q, emits rise/fall
// pulses and counts them over a programmable window with a start/done/ack handshake.
module jk_toggle_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 8,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             q_in,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  input  logic             ack,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEAS,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [WIN_W-1:0] r_win;
  logic [CNT_W-1:0] r_rise_cnt;
  logic [CNT_W-1:0] r_fall_cnt;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  logic             w_rise_max;
  logic             w_fall_max;
  logic [WIN_W-1:0] w_win_ld;

  assign w_s    = SYNC_EN ? r_sync2 : r_sync1;
  // Pulses decode flop outputs only, so they cannot glitch.
  assign w_rise = w_s & ~r_prev;
  assign w_fall = ~w_s & r_prev;

  assign w_rise_max = &r_rise_cnt;
  assign w_fall_max = &r_fall_cnt;
  assign w_win_ld   = (window == '0) ? WIN_W'(1) : window;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= q_in;
      r_sync2 <= r_sync1;
      r_prev  <= w_s;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_win      <= '0;
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_win      <= w_win_ld;
            r_rise_cnt <= '0;
            r_fall_cnt <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_MEAS;
          end
        end
        S_MEAS: begin
          if (w_rise && !w_rise_max)
            r_rise_cnt <= r_rise_cnt + CNT_W'(1);
          if (w_fall && !w_fall_max)
            r_fall_cnt <= r_fall_cnt + CNT_W'(1);
          // An event arriving at a saturated counter is lost.
          if ((w_rise && w_rise_max) ||
              (w_fall && w_fall_max))
            r_ovf <= 1'b1;
          r_win <= r_win - WIN_W'(1);
          if (r_win == WIN_W'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (ack) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rise_pulse = w_rise;
  assign fall_pulse = w_fall;
  assign busy       = r_busy;
  assign done       = r_done;
  assign rise_cnt   = r_rise_cnt;
  assign fall_cnt   = r_fall_cnt;
  assign overflow   = r_ovf;

endmodule
